// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
//  bcd_pkg : shared state encoding and digit-adjust helper for BCD conversion
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADJ   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // A digit >= 5 becomes 8..12 after the add, so the following shift carries into the next digit.
   function automatic logic [3:0] digit_adj(input logic [3:0] d);
      return (d >= ADD3_THRESH) ? d + 4'd3 : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
//  bcd_digit_adj : combinational add-3 correction for one BCD digit
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   assign digit_out = digit_adj(digit_in);

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_shift_add3.sv
// ----------------------------------------------------------------------------
//  bin_to_bcd_shift_add3 : sequential double-dabble binary-to-packed-BCD converter
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bin_to_bcd_shift_add3
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
)(
   input  logic                  CLK,
   input  logic                  Rst,
   input  logic                  St,
   input  logic [BIN_W-1:0]      Binary,
   output logic                  Busy,
   output logic                  Done,
   output logic [4*DIGITS-1:0]   BCD
);

   localparam int ZW    = 4*DIGITS + BIN_W;
   localparam int CNT_W = $clog2(BIN_W+1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W-1);

   if ((10**DIGITS) <= (2**BIN_W - 1)) begin : g_param_check
      $error("bin_to_bcd_shift_add3: DIGITS too small to represent 2**BIN_W-1");
   end

   state_t               state, state_n;
   logic [ZW-1:0]        z, z_n, z_adj, z_shl;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [4*DIGITS-1:0]  bcd_n;
   logic                 busy_n, done_n;

   // Only the digit fields are corrected; the binary part passes through untouched.
   assign z_adj[BIN_W-1:0] = z[BIN_W-1:0];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_adj u_adj (
         .digit_in  (z[BIN_W+4*i +: 4]),
         .digit_out (z_adj[BIN_W+4*i +: 4])
      );
   end

   assign z_shl = z << 1;

   always_ff @(posedge CLK) begin
      if (Rst) begin
         state <= IDLE;
         z     <= '0;
         cnt   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         BCD   <= '0;
      end else begin
         state <= state_n;
         z     <= z_n;
         cnt   <= cnt_n;
         Busy  <= busy_n;
         Done  <= done_n;
         BCD   <= bcd_n;
      end
   end

   always_comb begin
      state_n = state;
      z_n     = z;
      cnt_n   = cnt;
      bcd_n   = BCD;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (St) begin
               z_n     = ZW'(Binary);
               cnt_n   = '0;
               busy_n  = 1'b1;
               state_n = ADJ;
            end
         end
         ADJ: begin
            z_n     = z_adj;
            busy_n  = 1'b1;
            state_n = SHIFT;
         end
         SHIFT: begin
            z_n   = z_shl;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
               bcd_n   = z_shl[ZW-1 -: 4*DIGITS];
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               busy_n  = 1'b1;
               state_n = ADJ;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            z_n     = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_shift_add3.sv
// ----------------------------------------------------------------------------
//  tb_bin_to_bcd_shift_add3 : directed self-checking bench for the BCD converter
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bin_to_bcd_shift_add3;

   logic        CLK = 1'b0;
   logic        Rst = 1'b0;
   logic        St = 1'b0;
   logic [9:0]  Binary = '0;
   logic        Busy, Done;
   logic [15:0] BCD;

   int errors = 0;
   int checks = 0;
   logic prev_done = 1'b0;

   bin_to_bcd_shift_add3 #(.BIN_W(10), .DIGITS(4)) dut (
      .CLK    (CLK),
      .Rst    (Rst),
      .St     (St),
      .Binary (Binary),
      .Busy   (Busy),
      .Done   (Done),
      .BCD    (BCD)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   // Done must never be high on two consecutive samples.
   initial begin
      forever begin
         @(posedge CLK); #1;
         if (Done) begin
            checks++;
            if (prev_done) begin
               errors++;
               $display("FAIL done_width: Done high 2 cycles in a row, got 1 expected 0");
            end
         end
         prev_done = Done;
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic start(input int v);
      Binary = 10'(v);
      St     = 1'b1;
      step();
      St     = 1'b0;
   endtask

   // Start a conversion, wait for Done, check latency and result, then settle into IDLE.
   task automatic run_conv(input int v, input logic [15:0] exp);
      int lat;
      lat = 0;
      start(v);
      for (int k = 1; k <= 30; k++) begin
         step();
         if (Done) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat !== 20) begin
         errors++;
         $display("FAIL latency(%0d): got %0d cycles expected 20", v, lat);
      end
      checks++;
      if (BCD !== exp) begin
         errors++;
         $display("FAIL bcd(%0d): got %h expected %h", v, BCD, exp);
      end
      step();
      checks++;
      if (Done !== 1'b0) begin
         errors++;
         $display("FAIL done_clear(%0d): got %b expected 0", v, Done);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      step();
      step();
      Rst = 1'b0;
      checks++;
      if ({Busy, Done, BCD} !== 18'h0) begin
         errors++;
         $display("FAIL reset: got busy=%b done=%b bcd=%h expected 0/0/0000", Busy, Done, BCD);
      end
   endtask

   task automatic test_latency();
      int bad;
      bad = 0;
      start(1023);
      for (int k = 1; k <= 19; k++) begin
         step();
         if (Busy !== 1'b1 || Done !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL busy_window: got %0d bad cycles expected 0", bad);
      end
      step();
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL done_at_20: got done=%b busy=%b expected 1/0", Done, Busy);
      end
      checks++;
      if (BCD !== 16'h1023) begin
         errors++;
         $display("FAIL bcd_1023: got %h expected 1023", BCD);
      end
      step();
      checks++;
      if (Done !== 1'b0 || BCD !== 16'h1023) begin
         errors++;
         $display("FAIL hold_1023: got done=%b bcd=%h expected 0/1023", Done, BCD);
      end
   endtask

   task automatic test_values();
      run_conv(0,   16'h0000);
      run_conv(999, 16'h0999);
      run_conv(512, 16'h0512);
      run_conv(10,  16'h0010);
   endtask

   task automatic test_ignore_st();
      int n_done;
      logic [15:0] seen;
      n_done = 0;
      seen   = '0;
      start(345);
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k == 5) begin
            St     = 1'b1;
            Binary = 10'd77;
         end
         if (k == 6) St = 1'b0;
         if (Done) begin
            n_done++;
            seen = BCD;
         end
      end
      checks++;
      if (n_done !== 1) begin
         errors++;
         $display("FAIL ignore_st_count: got %0d Done pulses expected 1", n_done);
      end
      checks++;
      if (seen !== 16'h0345) begin
         errors++;
         $display("FAIL ignore_st_bcd: got %h expected 0345", seen);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      n_done = 0;
      start(700);
      repeat (6) step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      checks++;
      if ({Busy, Done, BCD} !== 18'h0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b bcd=%h expected 0/0/0000", Busy, Done, BCD);
      end
      for (int k = 0; k < 25; k++) begin
         step();
         if (Done || BCD !== 16'h0) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d stray cycles expected 0", n_done);
      end
      run_conv(123, 16'h0123);
   endtask

   task automatic test_back_to_back();
      int t[3];
      int n;
      int bad_bcd;
      n = 0;
      bad_bcd = 0;
      Binary = 10'd58;
      St     = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         step();
         if (Done) begin
            if (n < 3) t[n] = k;
            n++;
            if (BCD !== 16'h0058) bad_bcd++;
         end
      end
      St = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses expected 3", n);
      end
      checks++;
      if (n >= 3 && (t[1] - t[0] !== 22 || t[2] - t[1] !== 22)) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d,%0d expected 22,22", t[1] - t[0], t[2] - t[1]);
      end
      checks++;
      if (bad_bcd !== 0) begin
         errors++;
         $display("FAIL b2b_bcd: got %0d wrong results expected 0", bad_bcd);
      end
      for (int k = 0; k < 40 && Busy; k++) step();
      step();
      step();
   endtask

   task automatic test_exhaustive();
      for (int v = 0; v < 1024; v++) run_conv(v, ref_bcd(v));
   endtask

   initial begin
      test_reset();
      test_latency();
      test_values();
      test_ignore_st();
      test_reset_mid();
      test_back_to_back();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
